rollover_counter: RTL and testbench
===================================

# rollover_counter

Programmable modulo-k cycle counter that generates the one-cycle `roll_over` strobe consumed by the `clock` divider stage. The strobe fires every k enabled cycles, so the downstream `clock` output toggles once per k cycles. The block sits directly upstream of `clock` in the clock-generation chain. The modulus k has a compile-time default and can be reloaded at run time.

## Interface
Parameters:
- `K_MAX`, 16 — largest supported modulus; counter width `W = $clog2(K_MAX)`.
- `K_DEFAULT`, 3 — modulus after reset; legal range 2..K_MAX.

Ports:
- `i_clk`  in  1  — the single clock; all state updates on its rising edge.
- `i_reset`  in  1  — reset, asynchronous and active-high.
- `i_start`  in  1  — pulse; leaves IDLE and begins counting.
- `i_stop`  in  1  — pulse; returns to IDLE and clears the count.
- `i_en`  in  1  — count enable, valid in RUN.
- `i_load`  in  1  — pulse; requests a new modulus.
- `i_k`  in  W+1  — requested modulus, sampled when `i_load`=1.
- `o_count`  out  W  — current count, 0..k-1.
- `o_roll_over`  out  1  — registered one-cycle wrap strobe; feeds `clock`.
- `o_load_err`  out  1  — registered one-cycle pulse for a rejected load.
- `o_busy`  out  1  — high in RUN.

## Operation
- Reset, asynchronous, any time:
  - `o_count`=0, `o_roll_over`=0, `o_load_err`=0, `o_busy`=0.
  - `k_reg`=K_DEFAULT; state returns to IDLE.
- FSM states are IDLE and RUN.
- IDLE:
  - Count held at 0; `o_roll_over`=0.
  - `i_start`=1 → RUN. The count is not advanced on that edge.
- RUN, `i_en`=1:
  - Each edge: `count = (count == k_reg-1) ? 0 : count+1`.
  - `o_roll_over` is registered high for exactly the cycle in which the count has just wrapped to 0.
- RUN, `i_en`=0: count and `k_reg` hold; `o_roll_over`=0.
- RUN, `i_stop`=1 → IDLE on the next edge: count=0, `o_roll_over`=0.
- Priority per edge: reset > `i_stop` > `i_load` > count.
  - `i_start` and `i_stop` in the same cycle in IDLE: stay IDLE.
- Load with `i_k` in 2..K_MAX:
  - `k_reg`=`i_k`, count=0, `o_roll_over`=0.
  - State is unchanged.
- Load with `i_k` < 2 or `i_k` > K_MAX:
  - `o_load_err`=1 for one cycle.
  - `k_reg`, count and state are unchanged; counting proceeds normally that edge.
- Arithmetic: compare `count` zero-extended to W+1 bits against `k_reg`-1; no overflow past `k_reg`-1 is possible.

## Timing
- Latency from reset release with `i_start`, then `i_en` held high from the next cycle:
  - count 1, 2, …, k-1, then 0 with `o_roll_over`=1 on the k-th enabled edge.
  - For k=3 the strobe pattern is 0,0,1,0,0,1…
- Strobe period is exactly k enabled cycles. Disabled cycles stretch the period without losing position.
- `o_load_err` and the new `k_reg` take effect on the edge that samples `i_load`. The first wrap after a good load occurs k_new enabled edges later.
- Reset mid-count clears `o_roll_over` immediately (asynchronous), so `clock` sees no spurious strobe.

## Configuration
- `ROLLOVER_COUNTER_LOAD_EN` defined: run-time load path active as described above.
- `ROLLOVER_COUNTER_LOAD_EN` undefined:
  - `i_load` and `i_k` are ignored; `k_reg` is the constant K_DEFAULT.
  - `o_load_err` is tied to 0.
  - All other behaviour is identical.

## Structure
- Package `rollover_counter_pkg` holds:
  - the state enum `state_t` {IDLE, RUN};
  - the default constants for K_MAX and K_DEFAULT;
  - the function `k_legal(k, k_max)` used for load validation.
- No sub-module; next-count/wrap logic is a small combinational block inside the module.

## Test plan
- Reset 3 cycles, `i_start`, `i_en`=1, K_DEFAULT=3 → `o_count` 1,2,0,1,2,0; `o_roll_over` 0,0,1,0,0,1.
- `i_en` low for 2 cycles at count=1 with k=3 → count holds at 1; the wrap is delayed by exactly 2 cycles.
- Load `i_k`=5 in RUN → count=0; the next strobe follows 5 enabled edges later. Then load `i_k`=1 → `o_load_err` pulses once and k stays 5.
- Load `i_k`=K_MAX+1 → `o_load_err`=1 for one cycle; the period is unchanged.
- `i_reset` asserted mid-cycle at count=2 → `o_count`=0 and `o_roll_over`=0 without waiting for a clock edge; state is IDLE.
- Build without `ROLLOVER_COUNTER_LOAD_EN`, pulse `i_load` with `i_k`=7 → period remains 3 and `o_load_err` stays 0.

Source files
------------

// File: rtl/rollover_counter_pkg.sv
// ----------------------------------------------------------------------------
// rollover_counter_pkg
//   Shared types and constants for rollover_counter.
//   - state_t          : controller state (IDLE, RUN)
//   - K_MAX_DEFAULT    : default largest supported modulus
//   - K_DEFAULT_DEFAULT: default modulus after reset
//   - k_legal()        : validates a requested modulus against 2..k_max
// ----------------------------------------------------------------------------
package rollover_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int K_MAX_DEFAULT     = 16;
    localparam int K_DEFAULT_DEFAULT = 3;

    // A modulus below 2 would never produce a one-cycle strobe between
    // wraps, and anything above k_max does not fit the count register.
    function automatic logic k_legal(input int k, input int k_max);
        return (k >= 2) && (k <= k_max);
    endfunction

endpackage

// File: rtl/rollover_counter.sv
// ----------------------------------------------------------------------------
// rollover_counter
//   Programmable modulo-k cycle counter. Produces a registered one-cycle
//   o_roll_over strobe every k enabled cycles for the downstream clock
//   divider stage. The modulus resets to K_DEFAULT and may be reloaded at
//   run time when ROLLOVER_COUNTER_LOAD_EN is defined; without that macro
//   i_load/i_k are ignored and o_load_err is tied low.
//
// Ports:
//   i_clk        in   1    clock, rising edge
//   i_reset      in   1    asynchronous, active-high reset
//   i_start      in   1    pulse, IDLE -> RUN
//   i_stop       in   1    pulse, -> IDLE and clear count
//   i_en         in   1    count enable (RUN only)
//   i_load       in   1    pulse, request new modulus
//   i_k          in   W+1  requested modulus, sampled with i_load
//   o_count      out  W    current count, 0..k-1
//   o_roll_over  out  1    registered wrap strobe
//   o_load_err   out  1    registered pulse for a rejected load
//   o_busy       out  1    high while in RUN
//
// Per-edge priority: reset > stop > load > count.
// ----------------------------------------------------------------------------
module rollover_counter
    import rollover_counter_pkg::*;
#(
    parameter int  K_MAX     = K_MAX_DEFAULT,
    parameter int  K_DEFAULT = K_DEFAULT_DEFAULT,
    localparam int W         = $clog2(K_MAX)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W:0]   i_k,
    output logic [W-1:0] o_count,
    output logic         o_roll_over,
    output logic         o_load_err,
    output logic         o_busy
);

    state_t       state, state_n;
    logic [W-1:0] count, count_n;
    logic [W:0]   k_reg;
    logic         roll_q, roll_n;
    logic         err_q, err_n;
    logic         wrap;
    logic         load_ok;
    logic         load_bad;

`ifdef ROLLOVER_COUNTER_LOAD_EN
    assign load_ok  = i_load &&  k_legal(int'(i_k), K_MAX);
    assign load_bad = i_load && !k_legal(int'(i_k), K_MAX);

    // Modulus register; a stop on the same edge takes priority over the load.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            k_reg <= (W+1)'(K_DEFAULT);
        end else if (!i_stop && load_ok) begin
            k_reg <= i_k;
        end
    end
`else
    logic unused_load;

    assign load_ok     = 1'b0;
    assign load_bad    = 1'b0;
    assign k_reg       = (W+1)'(K_DEFAULT);
    assign unused_load = ^{i_load, i_k};
`endif

    // count is zero-extended to the width of k_reg; since count never
    // exceeds k_reg-1 this equality is the only wrap condition needed.
    assign wrap = ({1'b0, count} == (k_reg - (W+1)'(1)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            count  <= '0;
            roll_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            roll_q <= roll_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        roll_n  = 1'b0;
        err_n   = 1'b0;

        if (i_stop) begin
            state_n = IDLE;
            count_n = '0;
        end else if (load_ok) begin
            // Accepted load restarts the phase without changing state.
            count_n = '0;
        end else begin
            // A rejected load only flags; counting proceeds this edge.
            err_n = load_bad;
            case (state)
                IDLE: begin
                    count_n = '0;
                    if (i_start) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (i_en) begin
                        count_n = wrap ? '0 : count + W'(1);
                        roll_n  = wrap;
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    assign o_count     = count;
    assign o_roll_over = roll_q;
    assign o_load_err  = err_q;
    assign o_busy      = (state == RUN);

endmodule

// File: tb/tb_rollover_counter.sv
// ----------------------------------------------------------------------------
// tb_rollover_counter
//   Self-checking bench for rollover_counter. The reference model tracks the
//   number of enabled RUN edges since the last (re)start and derives the
//   count and strobe from it with modulo arithmetic. Honors
//   ROLLOVER_COUNTER_LOAD_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_rollover_counter;

    localparam int K_MAX     = 16;
    localparam int K_DEFAULT = 3;
    localparam int W         = $clog2(K_MAX);

`ifdef ROLLOVER_COUNTER_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic         i_stop;
    logic         i_en;
    logic         i_load;
    logic [W:0]   i_k;
    logic [W-1:0] o_count;
    logic         o_roll_over;
    logic         o_load_err;
    logic         o_busy;

    always #5 i_clk = ~i_clk;

    rollover_counter #(
        .K_MAX     (K_MAX),
        .K_DEFAULT (K_DEFAULT)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_en        (i_en),
        .i_load      (i_load),
        .i_k         (i_k),
        .o_count     (o_count),
        .o_roll_over (o_roll_over),
        .o_load_err  (o_load_err),
        .o_busy      (o_busy)
    );

    // ---------------- reference model ----------------
    int m_k;     // current modulus
    int m_n;     // enabled RUN edges since last restart
    bit m_run;   // controller running

    // Expected {busy, load_err, roll_over, count}
    logic [W+2:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_push(input bit err, input bit roll);
        exp_q.push_back({m_run, err, roll, W'(m_n % m_k)});
    endtask

    task automatic model_reset();
        m_k   = K_DEFAULT;
        m_n   = 0;
        m_run = 1'b0;
        model_push(1'b0, 1'b0);
    endtask

    task automatic model_step(input bit start, input bit stop, input bit en,
                              input bit load, input int k);
        bit err;
        bit roll;
        bit legal;
        err   = 1'b0;
        roll  = 1'b0;
        legal = (k >= 2) && (k <= K_MAX);
        if (stop) begin
            m_run = 1'b0;
            m_n   = 0;
        end else if (LOAD_EN && load && legal) begin
            m_k = k;
            m_n = 0;
        end else begin
            err = LOAD_EN && load;
            if (!m_run) begin
                m_n = 0;
                if (start) m_run = 1'b1;
            end else if (en) begin
                m_n++;
                roll = (m_n % m_k) == 0;
            end
        end
        model_push(err, roll);
    endtask

    task automatic compare_outputs(input string tag);
        logic [W+2:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_count"}, int'(o_count),     int'(e[W-1:0]));
            check({tag, "_roll"},  int'(o_roll_over), int'(e[W]));
            check({tag, "_err"},   int'(o_load_err),  int'(e[W+1]));
            check({tag, "_busy"},  int'(o_busy),      int'(e[W+2]));
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input string tag, input bit start, input bit stop,
                         input bit en, input bit load, input int k);
        i_start = start;
        i_stop  = stop;
        i_en    = en;
        i_load  = load;
        i_k     = (W+1)'(k);
        @(posedge i_clk);
        model_step(start, stop, en, load, k);
        #1;
        compare_outputs(tag);
    endtask

    task automatic run_en(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_en    = 1'b0;
        i_load  = 1'b0;
        i_k     = '0;
        repeat (3) @(posedge i_clk);
        #1;
        model_reset();
        compare_outputs("reset");
        i_reset = 1'b0;

        // Start, then k=3 counting: 1,2,0,1,2,0 with strobe on the zeros.
        cycle("start", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_en("k3", 6);

        // Enable gap at count=1: wrap delayed by exactly the gap.
        run_en("pre_gap", 1);
        cycle("gap", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cycle("gap", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_en("post_gap", 5);

        // Good load k=5, then rejected loads (too small, too large).
        cycle("load5", 1'b0, 1'b0, 1'b1, 1'b1, 5);
        run_en("k5", 6);
        cycle("load1", 1'b0, 1'b0, 1'b1, 1'b1, 1);
        run_en("k5_after_bad", 5);
        cycle("load_big", 1'b0, 1'b0, 1'b1, 1'b1, K_MAX + 1);
        run_en("k5_after_big", 5);
        cycle("load7_gap", 1'b0, 1'b0, 1'b0, 1'b1, 7);
        run_en("k7", 8);

        // Back to k=3, advance to count=2, then reset between edges.
        cycle("load3", 1'b0, 1'b0, 1'b1, 1'b1, 3);
        run_en("to_two", 2);
        #3;
        i_reset = 1'b1;
        #1;
        model_reset();
        compare_outputs("async_reset");
        @(posedge i_clk);
        #1;
        model_push(1'b0, 1'b0);
        compare_outputs("reset_hold");
        i_reset = 1'b0;

        // Stop handling.
        cycle("start2", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_en("run2", 2);
        cycle("stop", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle("start_stop", 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cycle("idle_en", 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 11) == 0),
                  int'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
